// File: rtl/nn_pkg.sv
// Shared constants, types and saturation helper for the dense-layer MAC engine.
// Q8.8 data, 40-bit accumulators, FSM state encoding.
package nn_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int ACC_W   = 40;
  localparam int N_LANES = 20;

  typedef logic signed [DATA_W-1:0] q8_8_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam logic signed [ACC_W:0] SAT_HI =
    (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SAT_LO =
    (ACC_W+1)'(-32768);

  // v is an already-shifted (integer-aligned) Q8.8 value
  function automatic q8_8_t sat_q8_8(
    input logic signed [ACC_W:0] v
  );
    if (v > SAT_HI)
      return 16'h7FFF;
    else if (v < SAT_LO)
      return 16'h8000;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron lane: signed MAC with clear, bias add and output post-processing.
// Ports: clk, rst_n, clr, en, bias, relu, w, a -> res (post-processed Q8.8).
// Optional LAYER_ROUND_EN: round half up before the output shift.
module mac_lane
  import nn_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  input  logic  bias,
  input  logic  relu,
  input  q8_8_t w,
  input  q8_8_t a,
  output q8_8_t res
);

  localparam int W2 = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] A_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

`ifdef LAYER_ROUND_EN
  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W-FRAC_W+1){1'b0}}, 1'b1,
     {(FRAC_W-1){1'b0}}};
`endif

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [W2-1:0]    prod;
  logic signed [ACC_W:0]   term;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   shf;
  q8_8_t                   sat;

  always_comb begin
    prod = W2'(w) * W2'(a);
    if (bias)
      term = {{(ACC_W+1-DATA_W-FRAC_W){w[DATA_W-1]}},
              w, {FRAC_W{1'b0}}};
    else
      term = {{(ACC_W+1-W2){prod[W2-1]}}, prod};
    sum = {acc[ACC_W-1], acc} + term;
    // clamp instead of wrapping so long runs keep their sign
    if (sum[ACC_W] != sum[ACC_W-1])
      acc_nxt = sum[ACC_W] ? A_MIN : A_MAX;
    else
      acc_nxt = sum[ACC_W-1:0];
  end

  always_comb begin
`ifdef LAYER_ROUND_EN
    rnd = {acc[ACC_W-1], acc} + HALF;
`else
    rnd = {acc[ACC_W-1], acc};
`endif
    shf = rnd >>> FRAC_W;
    sat = sat_q8_8(shf);
    res = (relu && sat[DATA_W-1]) ? '0 : sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc_nxt;
  end

endmodule

// File: rtl/layer_mac_engine.sv
// Dense-layer slice engine: streams activations against N_LANES weight RAMs,
// adds bias, post-processes and writes N_LANES results to the IO RAM.
// Ports: Clk, Reset(async low), Start, N_in, In_base, Out_base, W_base,
// Relu_en, W_Address/W_Q, IO_Address/IO_Wren/IO_D/IO_Q, Busy, Done.
// Option LAYER_ROUND_EN selects rounding in the lanes.
module layer_mac_engine
  import nn_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  Start,
  input  logic [ADDR_W-1:0]                     N_in,
  input  logic [ADDR_W-1:0]                     In_base,
  input  logic [ADDR_W-1:0]                     Out_base,
  input  logic [ADDR_W-1:0]                     W_base,
  input  logic                                  Relu_en,
  output logic [N_LANES-1:0][ADDR_W-1:0]        W_Address,
  input  logic [N_LANES-1:0][DATA_W-1:0]        W_Q,
  output logic [ADDR_W-1:0]                     IO_Address,
  output logic                                  IO_Wren,
  output logic [DATA_W-1:0]                     IO_D,
  input  logic [DATA_W-1:0]                     IO_Q,
  output logic                                  Busy,
  output logic                                  Done
);

  localparam int LW = $clog2(N_LANES);
  localparam logic [ADDR_W-1:0] DR_LAST =
    ADDR_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] WR_LAST =
    ADDR_W'(N_LANES - 1);

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] n_r;
  logic [ADDR_W-1:0] in_r;
  logic [ADDR_W-1:0] out_r;
  logic [ADDR_W-1:0] w_r;
  logic              relu_r;
  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] tag;
  logic              go;
  logic [LW-1:0]     k;
  logic [ADDR_W-1:0] wa;
  q8_8_t             res [N_LANES];

  assign go = (state == IDLE) && Start;
  assign k  = cnt[LW-1:0];

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (Start) nxt = FETCH;
      FETCH: if (cnt == n_r) nxt = DRAIN;
      DRAIN: if (cnt == DR_LAST) nxt = WRITE;
      WRITE: if (cnt == WR_LAST) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      n_r    <= '0;
      in_r   <= '0;
      out_r  <= '0;
      w_r    <= '0;
      relu_r <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (go) begin
        n_r    <= N_in;
        in_r   <= In_base;
        out_r  <= Out_base;
        w_r    <= W_base;
        relu_r <= Relu_en;
      end
    end
  end

  // valid/tag pipe tracks each issued index until its RAM data returns
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld <= '0;
      tag <= '0;
    end else begin
      vld[0] <= (state == FETCH);
      tag[0] <= (state == FETCH) && (cnt == n_r);
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  always_comb begin
    wa         = '0;
    IO_Address = '0;
    IO_Wren    = 1'b0;
    IO_D       = '0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (1'b1)
      (state == FETCH): begin
        wa         = w_r + cnt;
        IO_Address = in_r + cnt;
        Busy       = 1'b1;
      end
      (state == DRAIN): Busy = 1'b1;
      (state == WRITE): begin
        IO_Address = out_r + cnt;
        IO_Wren    = 1'b1;
        IO_D       = res[k];
        Busy       = 1'b1;
      end
      (state == DONE): Done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    for (int l = 0; l < N_LANES; l++)
      W_Address[l] = wa;
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    mac_lane u_lane (
      .clk   (Clk),
      .rst_n (Reset),
      .clr   (go),
      .en    (vld[RD_LAT-1]),
      .bias  (tag[RD_LAT-1]),
      .relu  (relu_r),
      .w     (W_Q[l]),
      .a     (IO_Q),
      .res   (res[l])
    );
  end

endmodule
